alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters: port 0 (integer pipeline EX stage) and port 1 (address/helper unit).
- Valid/ready request handshake per port and a single shared response channel tagged with the requester ID.
- Round-robin arbitration; one transaction in flight; result registered.
- Illegal opcodes are trapped before they reach the ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 24 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU, its opcode decoder and the ALU arbiter.
package alu_pkg;

    localparam int unsigned ALU_W  = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned NPORTS = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // True for the five opcodes the ALU implements; 011/100/101 are reserved.
    function automatic bit op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; reserved opcodes produce X and must be trapped upstream.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] y
);

    // Opcode decode and datapath; SLT is an unsigned compare.
    always_comb begin
        y = 'x;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_SLT: y = {{(ALU_W-1){1'b0}}, (a < b)};
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant: a lone requester wins, contention goes round-robin or to port 0.
module rr_arb2 #(
    parameter int unsigned RR_EN = 1
) (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic       gnt,
    output logic       gnt_any
);

    // Pick the winning port index.
    always_comb begin
        gnt_any = |valid;
        gnt     = 1'b0;
        if (valid == 2'b11) begin
            gnt = (RR_EN != 0) ? ~rr_last : 1'b0;
        end else begin
            gnt = valid[1] & ~valid[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with a single tagged, registered response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned RR_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][OP_W-1:0]   req_op,
    input  logic [1:0][DW-1:0]     req_a,
    input  logic [1:0][DW-1:0]     req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DW-1:0]          rsp_data,
    output logic                   rsp_err
);

    arb_state_t          state;
    logic                rr_last;
    logic                gnt;
    logic                gnt_any;
    logic                can_accept;
    logic                accept;
    logic [OP_W-1:0]     sel_op;
    logic [DW-1:0]       sel_a;
    logic [DW-1:0]       sel_b;
    logic [DW-1:0]       alu_y;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .valid   (req_valid),
        .rr_last (rr_last),
        .gnt     (gnt),
        .gnt_any (gnt_any)
    );

    // Operand mux for the granted port feeding the shared ALU.
    always_comb begin
        sel_op = req_op[gnt];
        sel_a  = req_a[gnt];
        sel_b  = req_b[gnt];
    end

    alu u_alu (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (alu_y)
    );

    // Accept when the response slot is empty or retiring this edge; only the winner sees ready.
    always_comb begin
        can_accept = (state == IDLE) || rsp_ready;
        accept     = gnt_any && can_accept && !reset;
        req_ready  = 2'b00;
        if (accept) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Response register, FSM and fairness pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rr_last   <= 1'b1;
        end else if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt;
            if (op_legal(sel_op)) begin
                rsp_data <= alu_y;
                rsp_err  <= 1'b0;
            end else begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
            if (req_valid == 2'b11) begin
                rr_last <= gnt;
            end
        end else if ((state == HOLD) && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][2:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             rsp_ready;

    logic [1:0]  req_ready,  fp_req_ready;
    logic        rsp_valid,  fp_rsp_valid;
    logic        rsp_id,     fp_rsp_id;
    logic [31:0] rsp_data,   fp_rsp_data;
    logic        rsp_err,    fp_rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(32), .RR_EN(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    alu_arbiter #(.DW(32), .RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(fp_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [31:0] data,
                           input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_data"},  rsp_data,       data);
        chk({tag, "_err"},   32'(rsp_err),   32'(err));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state; ready held low even with requests pending.
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        req_valid = 2'b00;
        reset     = 1'b0;
        step();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single request: ADD 5+7.
        req_valid = 2'b01;
        req_op[0] = 3'b010; req_a[0] = 32'd5; req_b[0] = 32'd7;
        #1;
        chk("single_ready", 32'(req_ready), 32'b01);
        step();
        chk_rsp("single", 1'b0, 32'd12, 1'b0);
        req_valid = 2'b00;
        step();
        chk("retire_valid", 32'(rsp_valid), 32'd0);

        // Contention: grants alternate starting with port 0.
        req_valid = 2'b11;
        req_op[0] = 3'b110; req_a[0] = 32'd10; req_b[0] = 32'd3;
        req_op[1] = 3'b111; req_a[1] = 32'd2;  req_b[1] = 32'd9;
        #1;
        chk("cont_ready0", 32'(req_ready), 32'b01);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) chk_rsp("cont_p0", 1'b0, 32'd7, 1'b0);
            else            chk_rsp("cont_p1", 1'b1, 32'd1, 1'b0);
            chk("cont_fp_id",   32'(fp_rsp_id),   32'd0);
            chk("cont_fp_data", fp_rsp_data,      32'd7);
        end

        // Backpressure: response frozen and nobody accepted.
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready_now", 32'(req_ready), 32'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_rsp("bp_hold", 1'b1, 32'd1, 1'b0);
            chk("bp_req_ready", 32'(req_ready), 32'b00);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b01);
        step();
        chk_rsp("bp_release", 1'b0, 32'd7, 1'b0);

        // Illegal opcode on port 1, then a legal OR.
        req_valid = 2'b10;
        req_op[1] = 3'b100; req_a[1] = 32'h1234; req_b[1] = 32'h5678;
        step();
        chk_rsp("illegal", 1'b1, 32'd0, 1'b1);
        req_op[1] = 3'b001; req_a[1] = 32'hF0; req_b[1] = 32'h0F;
        step();
        chk_rsp("or_after_illegal", 1'b1, 32'hFF, 1'b0);

        // Wrap-around and unsigned-compare edge values on port 0.
        req_valid = 2'b01;
        req_op[0] = 3'b110; req_a[0] = 32'd0; req_b[0] = 32'd1;
        step();
        chk_rsp("sub_wrap", 1'b0, 32'hFFFF_FFFF, 1'b0);
        req_op[0] = 3'b010; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
        step();
        chk_rsp("add_wrap", 1'b0, 32'd0, 1'b0);
        req_op[0] = 3'b111; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
        step();
        chk_rsp("slt_unsigned", 1'b0, 32'd0, 1'b0);
        req_op[0] = 3'b111; req_a[0] = 32'd1; req_b[0] = 32'hFFFF_FFFF;
        step();
        chk_rsp("slt_true", 1'b0, 32'd1, 1'b0);
        req_op[0] = 3'b000; req_a[0] = 32'hFF00_FF00; req_b[0] = 32'h0FF0_0FF0;
        step();
        chk_rsp("and", 1'b0, 32'h0F00_0F00, 1'b0);

        // Reset while holding a stalled response; port 0 gets first grant afterwards.
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step();
        chk("pre_reset_hold", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("reset_drop_valid", 32'(rsp_valid), 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_op[0] = 3'b001; req_a[0] = 32'h3;  req_b[0] = 32'h4;
        req_op[1] = 3'b010; req_a[1] = 32'h10; req_b[1] = 32'h20;
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'b01);
        step();
        chk_rsp("post_reset_p0", 1'b0, 32'h7, 1'b0);
        step();
        chk_rsp("post_reset_p1", 1'b1, 32'h30, 1'b0);
        req_valid = 2'b00;
        step();
        chk("final_idle", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
